// File: rtl/imm_gen_pipe_if.sv
// Stream bundle for the decode-stage immediate generator.
//   flush      : synchronous discard of every buffered entry
//   in_valid   : instr/imm_src carry a word
//   in_ready   : generator can take a word this cycle
//   instr      : 32-bit instruction word
//   imm_src    : format code (000 I, 001 S, 010 B, 011 U, 100 J, 101 jalr, 11x illegal)
//   out_valid  : imm_ext/imm_type/illegal carry a result
//   out_ready  : consumer takes the result this cycle
//   imm_ext    : sign-extended immediate, XLEN bits
//   imm_type   : resolved format code (111 when illegal)
//   illegal    : unknown format, imm_ext forced to zero
// master = producer/consumer side, slave = the generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_ext;
    logic [2:0]      imm_type;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm_ext, imm_type, illegal
    );

    modport slave (
        input  flush, in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm_ext, imm_type, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I immediate generator with a 2-entry skid buffer.
// Immediate extraction is combinational on the input word; the result is
// captured either into the output register or, when the output is stalled,
// into a single skid entry. Order is FIFO, throughput 1/cycle, latency 1.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : imm_gen_pipe_if.slave stream bundle (see interface header)
// Parameters:
//   XLEN        : 32 or 64, width of imm_ext
//   AUTO_DECODE : 1 derives the format from instr[6:0], 0 uses imm_src
module imm_gen_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b0
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_I    = 3'b000,
        FMT_S    = 3'b001,
        FMT_B    = 3'b010,
        FMT_U    = 3'b011,
        FMT_J    = 3'b100,
        FMT_JALR = 3'b101,
        FMT_ILL  = 3'b111
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            ill;
    } entry_t;

    fmt_e        fmt_src;
    fmt_e        fmt_opc;
    fmt_e        fmt;
    logic [31:0] imm32;
    entry_t      entry_in;

    entry_t      out_q;
    entry_t      skid_q;
    logic        out_valid_q;
    logic        skid_valid_q;
    logic        in_ready_q;

    logic        in_hs;
    logic        out_free;

    // Format from the explicit code; 11x is illegal.
    always_comb begin
        fmt_src = FMT_ILL;
        case (bus.imm_src)
            3'b000:  fmt_src = FMT_I;
            3'b001:  fmt_src = FMT_S;
            3'b010:  fmt_src = FMT_B;
            3'b011:  fmt_src = FMT_U;
            3'b100:  fmt_src = FMT_J;
            3'b101:  fmt_src = FMT_JALR;
            default: fmt_src = FMT_ILL;
        endcase
    end

    // Format from the opcode field.
    always_comb begin
        fmt_opc = FMT_ILL;
        case (bus.instr[6:0])
            7'b0010011,
            7'b0000011,
            7'b1110011: fmt_opc = FMT_I;
            7'b1100111: fmt_opc = FMT_JALR;
            7'b0100011: fmt_opc = FMT_S;
            7'b1100011: fmt_opc = FMT_B;
            7'b0110111,
            7'b0010111: fmt_opc = FMT_U;
            7'b1101111: fmt_opc = FMT_J;
            default:    fmt_opc = FMT_ILL;
        endcase
    end

    assign fmt = AUTO_DECODE ? fmt_opc : fmt_src;

    // 32-bit immediate; every format is sign-correct at bit 31, so a single
    // signed widening covers XLEN=64 (including U, which carries instr[31]).
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I, FMT_JALR:
                imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            FMT_S:
                imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            FMT_B:
                imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                         bus.instr[30:25], bus.instr[11:8], 1'b0};
            FMT_U:
                imm32 = {bus.instr[31:12], 12'h000};
            FMT_J:
                imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                         bus.instr[20], bus.instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    always_comb begin
        entry_in     = '0;
        entry_in.imm = XLEN'($signed(imm32));
        entry_in.fmt = fmt;
        entry_in.ill = (fmt == FMT_ILL);
    end

    assign in_hs    = bus.in_valid & in_ready_q;
    // Output register can be loaded when empty or being drained this cycle.
    assign out_free = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (bus.flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (out_free) begin
            // in_ready_q is low whenever skid holds data, so in_hs and a
            // full skid never coincide here.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (in_hs) begin
                out_q       <= entry_in;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_hs) begin
            skid_q       <= entry_in;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.imm_ext   = out_q.imm;
    assign bus.imm_type  = out_q.fmt;
    assign bus.illegal   = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN32/explicit code,
// XLEN32/opcode decode, XLEN64/opcode decode) share one stimulus stream.
// A queue model tracks accepted words; immediates are recomputed from the
// instruction-set field rules and checked every cycle at the falling edge.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  imm_src = '0;
    logic        out_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if0 ();
    imm_gen_pipe_if #(.XLEN(32)) if1 ();
    imm_gen_pipe_if #(.XLEN(64)) if2 ();

    assign if0.flush = flush;  assign if1.flush = flush;  assign if2.flush = flush;
    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
    assign if0.instr = instr;  assign if1.instr = instr;  assign if2.instr = instr;
    assign if0.imm_src = imm_src;  assign if1.imm_src = imm_src;  assign if2.imm_src = imm_src;
    assign if0.out_ready = out_ready;  assign if1.out_ready = out_ready;  assign if2.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic [31:0] w;
        logic [2:0]  src;
    } txn_t;

    txn_t q[$];

    logic [6:0] opc_tbl [0:9] = '{7'h13, 7'h03, 7'h73, 7'h67, 7'h23,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Immediate per field rules; sg is all-ones when instr[31]=1.
    function automatic void ref_imm(input logic [31:0] w, input logic [2:0] src,
                                    input bit auto_dec, output logic [63:0] imm,
                                    output logic [2:0] typ, output logic ill);
        logic [2:0] f;
        longint     sg;
        sg = longint'($signed(w) >>> 31);
        if (auto_dec) begin
            case (w[6:0])
                7'h13, 7'h03, 7'h73: f = 3'd0;
                7'h67:               f = 3'd5;
                7'h23:               f = 3'd1;
                7'h63:               f = 3'd2;
                7'h37, 7'h17:        f = 3'd3;
                7'h6F:               f = 3'd4;
                default:             f = 3'd7;
            endcase
        end else begin
            f = (src >= 3'd6) ? 3'd7 : src;
        end
        typ = f;
        ill = (f == 3'd7);
        case (f)
            3'd0, 3'd5: imm = (sg << 11) | 64'(w[30:20]);
            3'd1:       imm = (sg << 11) | 64'({w[30:25], w[11:7]});
            3'd2:       imm = (sg << 12) | 64'({w[7], w[30:25], w[11:8], 1'b0});
            3'd3:       imm = (sg << 31) | 64'({w[30:12], 12'h000});
            3'd4:       imm = (sg << 20) | 64'({w[19:12], w[20], w[30:21], 1'b0});
            default:    imm = '0;
        endcase
    endfunction

    // Flow model: queue holds output register then skid entry.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            automatic bit ih = in_valid && (q.size() < 2);
            automatic bit oh = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (oh) void'(q.pop_front());
                if (ih) q.push_back('{w: instr, src: imm_src});
            end
        end
    end

    task automatic cmp_inst(input string nm, input bit auto_dec, input int xlen,
                            input logic ov, input logic ir, input logic [63:0] imm,
                            input logic [2:0] typ, input logic ill);
        logic [63:0] e_imm;
        logic [2:0]  e_typ;
        logic        e_ill;
        logic [63:0] mask;
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        chk({nm, ".in_ready"}, 64'(ir), 64'(q.size() < 2));
        chk({nm, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
        if (q.size() > 0) begin
            ref_imm(q[0].w, q[0].src, auto_dec, e_imm, e_typ, e_ill);
            chk({nm, ".imm_ext"}, imm, e_imm & mask);
            chk({nm, ".imm_type"}, 64'(typ), 64'(e_typ));
            chk({nm, ".illegal"}, 64'(ill), 64'(e_ill));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp_inst("u0", 1'b0, 32, if0.out_valid, if0.in_ready, 64'(if0.imm_ext), if0.imm_type, if0.illegal);
            cmp_inst("u1", 1'b1, 32, if1.out_valid, if1.in_ready, 64'(if1.imm_ext), if1.imm_type, if1.illegal);
            cmp_inst("u2", 1'b1, 64, if2.out_valid, if2.in_ready, if2.imm_ext, if2.imm_type, if2.illegal);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] w2 [0:2] = '{32'hFE11_2E23, 32'h1234_50B7, 32'hFF9F_F06F};
    logic [31:0] e2 [0:2] = '{32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFF8};

    initial begin
        logic [63:0] p_imm;
        logic [2:0]  p_typ;
        logic        p_ill;

        // Model pins against hand-computed values.
        ref_imm(32'hFE11_2E23, 3'd0, 1'b1, p_imm, p_typ, p_ill);
        chk("pin_S", p_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        ref_imm(32'h0000_0063 | 32'h8000_0000, 3'd0, 1'b1, p_imm, p_typ, p_ill);
        chk("pin_B", p_imm, 64'hFFFF_FFFF_FFFF_F000);
        ref_imm(32'h0000_0000, 3'd7, 1'b0, p_imm, p_typ, p_ill);
        chk("pin_ILL", {p_imm[59:0], p_typ, p_ill}, {60'h0, 3'b111, 1'b1});

        // Reset state.
        #23;
        chk("rst.out_valid", 64'({if0.out_valid, if1.out_valid, if2.out_valid}), 64'h0);
        chk("rst.in_ready", 64'({if0.in_ready, if1.in_ready, if2.in_ready}), 64'h7);
        chk("rst.imm_ext", if2.imm_ext | 64'(if0.imm_ext), 64'h0);
        chk("rst.type_ill", 64'({if0.imm_type, if0.illegal, if2.imm_type, if2.illegal}), 64'h0);
        rst = 1'b0;
        step();

        // I-type through the explicit code and opcode paths.
        in_valid = 1'b1; instr = 32'hFFF0_0093; imm_src = 3'b000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1.imm_ext", 64'(if0.imm_ext), 64'hFFFF_FFFF);
        chk("t1.imm_type", 64'(if0.imm_type), 64'h0);
        chk("t6.imm64_I", if2.imm_ext, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // Back-to-back opcode-decoded stream.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr = w2[k];
            step();
            chk($sformatf("t2.imm_ext[%0d]", k), 64'(if1.imm_ext), 64'(e2[k]));
        end
        in_valid = 1'b0;
        step();

        // Back-pressure: two accepted, third held off until skid empties.
        out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'b000;
        instr = 32'h0010_0093; step();
        chk("t3.first", 64'(if0.imm_ext), 64'h1);
        instr = 32'h0020_0093; step();
        chk("t3.skid_full", 64'(if0.in_ready), 64'h0);
        instr = 32'h0030_0093; step();
        chk("t3.held", 64'({if0.in_ready, if0.imm_ext}), {31'h0, 1'b0, 32'h1});
        out_ready = 1'b1; step();
        chk("t3.second", 64'({if0.in_ready, if0.imm_ext}), {31'h0, 1'b1, 32'h2});
        step();
        chk("t3.third", 64'(if0.imm_ext), 64'h3);
        in_valid = 1'b0; step();

        // Flush with output and skid full while offering a word.
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0040_0093; step();
        instr = 32'h0050_0093; step();
        flush = 1'b1; instr = 32'h0060_0093; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4.flush", 64'({if0.out_valid, if0.in_ready}), 64'h1);
        out_ready = 1'b1; step(); step();

        // Illegal formats.
        in_valid = 1'b1; instr = 32'h0000_007F; imm_src = 3'b110; step();
        in_valid = 1'b0;
        chk("t5.auto", 64'({if1.illegal, if1.imm_type, if1.imm_ext}), {28'h0, 1'b1, 3'b111, 32'h0});
        chk("t5.src", 64'({if0.illegal, if0.imm_type, if0.imm_ext}), {28'h0, 1'b1, 3'b111, 32'h0});
        step();

        // XLEN=64 U-type, then asynchronous reset mid-stream.
        in_valid = 1'b1; instr = 32'h8000_00B7; step();
        chk("t6.imm64_U", if2.imm_ext, 64'hFFFF_FFFF_8000_0000);
        out_ready = 1'b0; instr = 32'h0070_0093; step();
        #1 rst = 1'b1;
        #1;
        chk("t6.rst_async", 64'({if2.out_valid, if2.in_ready, if0.out_valid}), 64'h2);
        rst = 1'b0; in_valid = 1'b0;
        step();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] w;
            w = $urandom;
            if (($urandom % 8) != 0) w[6:0] = opc_tbl[$urandom % 10];
            instr     = w;
            imm_src   = 3'($urandom % 8);
            in_valid  = (($urandom % 4) != 0);
            out_ready = (($urandom % 10) < 6);
            flush     = (($urandom % 40) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
